irq_ctrl: RTL

Interrupt controller that produces the single `irq_in` request consumed by the special-register block. It collects up to 16 peripheral interrupt sources and applies mask, edge/level selection and fixed priority. It holds the request to the core until the core takes the vector, then records the claimed source until software writes end-of-interrupt. It sits between the peripherals and the core, and is programmed through a small register window on the data bus.

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_sync.sv | 32 +++
 rtl/irq_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encodings and the architectural source limit.
package irq_pkg;

   localparam int IRQ_MAX_SRC = 16;

   localparam logic [2:0] IRQ_PENDING = 3'd0;
   localparam logic [2:0] IRQ_MASK    = 3'd1;
   localparam logic [2:0] IRQ_EDGE    = 3'd2;
   localparam logic [2:0] IRQ_CLAIM   = 3'd3;
   localparam logic [2:0] IRQ_EOI     = 3'd4;
   localparam logic [2:0] IRQ_STATUS  = 3'd5;

   typedef enum logic [1:0] {
      IRQ_IDLE  = 2'b00,
      IRQ_REQ   = 2'b01,
      IRQ_INSVC = 2'b10
   } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: 2-flop synchronizer followed by a previous-value
// flop so a rising edge of the synchronized level can be detected.
module irq_sync
   import irq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic src_i,
   output logic level_o,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source synchronizers, mask/edge selection,
// fixed-priority select (source 0 highest), request/claim FSM, register window.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src_in,
   input  logic            irq_en,
   input  logic            irq_ack,
   output logic            irq_out,
   input  logic [2:0]      reg_addr,
   input  logic [15:0]     reg_wdata,
   input  logic            reg_we,
   output logic [15:0]     reg_rdata
);

   logic [NSRC-1:0] level;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] edge_q, edge_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] win_oh;
   logic [NSRC-1:0] claim_clr;
   logic [NSRC-1:0] w1c;
   logic [3:0]      win;
   logic [3:0]      claim_id_q, claim_id_d;
   logic            claim_vld_q, claim_vld_d;
   logic            irq_q, irq_d;
   logic            eoi_wr;
   irq_state_e      state_q, state_d;

   function automatic logic [15:0] ext16(input logic [NSRC-1:0] v);
      logic [15:0] r;
      r         = '0;
      r[NSRC-1:0] = v;
      return r;
   endfunction

   for (genvar g = 0; g < NSRC; g++) begin : g_sync
      irq_sync u_sync (
         .clk     (clk),
         .rst     (rst),
         .src_i   (src_in[g]),
         .level_o (level[g]),
         .rise_o  (rise[g])
      );
   end

   // Edge sources read the sticky flop, level sources read the synchronized line.
   assign pending = (edge_q & pend_q) | (~edge_q & level);
   assign active  = pending & mask_q;
   assign eoi_wr  = reg_we && (reg_addr == IRQ_EOI);
   assign w1c     = (reg_we && (reg_addr == IRQ_PENDING)) ? reg_wdata[NSRC-1:0] : '0;

   always_comb begin
      win    = '0;
      win_oh = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            win       = 4'(i);
            win_oh    = '0;
            win_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      claim_vld_d = claim_vld_q;
      claim_id_d  = claim_id_q;
      claim_clr   = '0;
      case (state_q)
         IRQ_IDLE: begin
            if ((active != '0) && irq_en && !claim_vld_q) state_d = IRQ_REQ;
         end
         IRQ_REQ: begin
            // A vanished request is withdrawn even if an ack arrives with it.
            if (active == '0) begin
               state_d = IRQ_IDLE;
            end else if (irq_ack) begin
               claim_vld_d = 1'b1;
               claim_id_d  = win;
               claim_clr   = win_oh;
               state_d     = IRQ_INSVC;
            end
         end
         IRQ_INSVC: begin
            if (eoi_wr) begin
               claim_vld_d = 1'b0;
               claim_id_d  = '0;
               state_d     = IRQ_IDLE;
            end
         end
         default: state_d = IRQ_IDLE;
      endcase
      irq_d = (state_d == IRQ_REQ);
   end

   // A new rising edge outranks both W1C and claim-clear on the same bit.
   assign pend_d = edge_q & (rise | (pend_q & ~w1c & ~claim_clr));
   assign mask_d = (reg_we && (reg_addr == IRQ_MASK)) ? reg_wdata[NSRC-1:0] : mask_q;
   assign edge_d = (reg_we && (reg_addr == IRQ_EDGE)) ? reg_wdata[NSRC-1:0] : edge_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IRQ_IDLE;
         irq_q       <= 1'b0;
         pend_q      <= '0;
         mask_q      <= '0;
         edge_q      <= '0;
         claim_vld_q <= 1'b0;
         claim_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         irq_q       <= irq_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         edge_q      <= edge_d;
         claim_vld_q <= claim_vld_d;
         claim_id_q  <= claim_id_d;
      end
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         IRQ_PENDING: reg_rdata = ext16(pending);
         IRQ_MASK:    reg_rdata = ext16(mask_q);
         IRQ_EDGE:    reg_rdata = ext16(edge_q);
         IRQ_CLAIM:   reg_rdata = {claim_vld_q, 11'd0, claim_id_q};
         IRQ_STATUS:  reg_rdata = {14'd0, state_q};
         default:     reg_rdata = '0;
      endcase
   end

   assign irq_out = irq_q;

endmodule
